mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage. Consumes EX results (rd, op, ALU result, store data, mem_read/mem_write, valid) and drives a single-outstanding data-memory request/response port.
- Presents a registered writeback bundle to WB.
- Stalls EX through ready_out while a memory access is in flight.
- Non-memory ops pass through with 1-cycle latency.

Parameters:
- ADDR_W, 32, data-memory address width; taken from alu_result_in[ADDR_W-1:0].
- DATA_W, 32, data width of store data, load data and wb_data.

Ports:
- clk  input  1  clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- rd_in  input  4  destination register from EX.
- op_in  input  4  opcode (cpu_defs_pkg encoding), forwarded to op_out.
- alu_result_in  input  32  ALU result, or effective address for LOAD/STORE.
- store_data_in  input  32  store data.
- mem_read_in  input  1  load request flag.
- mem_write_in  input  1  store request flag.
- valid_in  input  1  EX bundle valid.
- ready_out  output  1  MEM can accept a bundle this cycle.
- dreq_valid  output  1  memory request valid.
- dreq_ready  input  1  memory accepts request.
- dreq_we  output  1  1 = store, 0 = load.
- dreq_addr  output  ADDR_W  word-aligned address.
- dreq_wdata  output  DATA_W  store data.
- drsp_valid  input  1  load data valid; 1-cycle pulse.
- drsp_rdata  input  DATA_W  load data.
- rd_out  output  4  WB destination register.
- op_out  output  4  WB opcode.
- wb_data  output  DATA_W  writeback value.
- wb_en  output  1  register write enable.
- err_out  output  1  misaligned or illegal access flagged.
- valid_out  output  1  WB bundle valid; 1-cycle pulse per instruction.

Behaviour:
- Reset, asynchronous: state = IDLE. dreq_valid, valid_out, wb_en and err_out are 0. rd_out, op_out, wb_data, dreq_addr and dreq_wdata are 0. ready_out is 1 once reset is released.
- FSM states: IDLE, REQ, WAIT_RSP.
- ready_out is 1 only in IDLE. A transfer from EX occurs when valid_in && ready_out.
- IDLE, transfer with mem_read_in = 0 and mem_write_in = 0:
  - Next cycle: valid_out = 1, wb_data = alu_result_in, wb_en = (rd_in != 0), err_out = 0.
  - Stay in IDLE, so back-to-back ALU ops flow at 1 per cycle.
- IDLE, transfer with exactly one of mem_read_in / mem_write_in set, and alu_result_in[1:0] == 0:
  - Latch rd, op, address, wdata and we into internal registers.
  - Go to REQ; dreq_valid = 1 from the next cycle.
- IDLE, illegal or misaligned memory transfer (both mem flags set, or address[1:0] != 0):
  - No memory request is issued.
  - Next cycle: valid_out = 1, err_out = 1, wb_en = 0, wb_data = alu_result_in.
- REQ:
  - dreq_valid, dreq_we, dreq_addr and dreq_wdata are held stable until dreq_ready.
  - Store, handshake (dreq_valid && dreq_ready): go to IDLE. Next cycle valid_out = 1, wb_en = 0, wb_data = store address.
  - Load, handshake: go to WAIT_RSP; dreq_valid drops the next cycle.
- WAIT_RSP:
  - On drsp_valid: go to IDLE. Next cycle valid_out = 1, wb_data = drsp_rdata, wb_en = (rd != 0), err_out = 0.
  - No timeout; the stage waits indefinitely.
- drsp_valid outside WAIT_RSP is ignored.
- A response in the same cycle as the request handshake is not legal. The memory returns data no earlier than the cycle after acceptance.
- valid_out is low in every cycle without a completion. rd_out, op_out and wb_data hold their last values when valid_out = 0.
- Latencies:
  - ALU op: 1 cycle.
  - Store: 2 + (dreq_ready wait) cycles.
  - Load: acceptance → dreq_valid at +1; drsp_valid at cycle M → valid_out at M+1.
- Reset mid-operation: the FSM returns to IDLE and dreq_valid drops immediately; any in-flight access is abandoned. The memory side is reset by the same rst_n.
- valid_in while ready_out = 0: EX must hold its bundle, and MEM does not sample it.

Decomposition:
- cpu_defs_pkg additions:
  - mem_state_t enum: IDLE, REQ, WAIT_RSP.
  - WORD_ALIGN_MASK = 2'b11.
  - Reuse the existing OP_* codes.
- No sub-module needed: one FSM plus the output register. Optionally a mem_req_reg holding the latched request fields.

Test Plan:
- ALU pass-through: ADD, rd = 5, alu = 0x0000_0030, valid 1 cycle → next cycle valid_out = 1, wb_data = 0x30, wb_en = 1. Back-to-back ADDs give valid_out every cycle.
- Load with stalls: LOAD, rd = 3, addr = 0x100, dreq_ready held low 2 cycles, then high; drsp_rdata = 0xDEAD_BEEF arrives 3 cycles later.
  - dreq_addr = 0x100 and dreq_we = 0 stable while waiting; ready_out = 0 throughout.
  - valid_out = 1 the cycle after drsp_valid, with wb_data = 0xDEADBEEF, wb_en = 1.
- Store: STORE, addr = 0x204, data = 0x1234_5678, dreq_ready = 1 immediately → dreq_we = 1, dreq_wdata = 0x12345678. valid_out = 1 with wb_en = 0 two cycles after acceptance.
- Misaligned: LOAD, addr = 0x102 → dreq_valid never asserts; next cycle valid_out = 1, err_out = 1, wb_en = 0.
- Register 0 writeback: LOAD, rd = 0 → completes normally with wb_en = 0.
- Reset in WAIT_RSP: assert rst_n = 0 asynchronously → all outputs 0 immediately. After release, ready_out = 1; a stray drsp_valid is ignored and valid_out stays 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode encoding plus the MEM-stage state and request types.
package cpu_defs_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SLT   = 4'h5;
  localparam logic [3:0] OP_SHL   = 4'h6;
  localparam logic [3:0] OP_SHR   = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_BEQ   = 4'hA;
  localparam logic [3:0] OP_JMP   = 4'hB;
  localparam logic [3:0] OP_NOP   = 4'hF;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } mem_state_t;

  // Control fields of the access currently owned by the MEM stage.
  typedef struct packed {
    logic [3:0] rd;
    logic [3:0] op;
    logic       we;
  } mem_req_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Pipeline MEM stage: single-outstanding data-memory access with a registered
// writeback bundle; ALU results bypass the memory port with one cycle of latency.
module mem_stage
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        rd_in,
  input  logic [3:0]        op_in,
  input  logic [31:0]       alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              dreq_valid,
  input  logic              dreq_ready,
  output logic              dreq_we,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [DATA_W-1:0] dreq_wdata,
  input  logic              drsp_valid,
  input  logic [DATA_W-1:0] drsp_rdata,
  output logic [3:0]        rd_out,
  output logic [3:0]        op_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en,
  output logic              err_out,
  output logic              valid_out
);

  mem_state_t state;
  mem_req_t   req;

  logic accept;
  logic is_mem;
  logic illegal;

  assign ready_out = (state == IDLE);
  assign accept    = valid_in && ready_out;
  assign is_mem    = mem_read_in || mem_write_in;
  assign illegal   = (mem_read_in && mem_write_in) || is_misaligned(alu_result_in[1:0]);

  // dreq_we/addr/wdata come straight from the latched request, so they are
  // stable for the whole REQ phase without any extra muxing.
  assign dreq_we = req.we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req        <= '0;
      dreq_valid <= 1'b0;
      dreq_addr  <= '0;
      dreq_wdata <= '0;
      rd_out     <= '0;
      op_out     <= '0;
      wb_data    <= '0;
      wb_en      <= 1'b0;
      err_out    <= 1'b0;
      valid_out  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; these defaults make the
      // completion flags single-cycle pulses and are overridden below.
      valid_out <= 1'b0;
      wb_en     <= 1'b0;
      err_out   <= 1'b0;

      unique case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem || illegal) begin
              rd_out    <= rd_in;
              op_out    <= op_in;
              wb_data   <= DATA_W'(alu_result_in);
              wb_en     <= !is_mem && (rd_in != 4'd0);
              err_out   <= is_mem;
              valid_out <= 1'b1;
            end else begin
              req.rd     <= rd_in;
              req.op     <= op_in;
              req.we     <= mem_write_in;
              dreq_addr  <= alu_result_in[ADDR_W-1:0];
              dreq_wdata <= store_data_in;
              dreq_valid <= 1'b1;
              state      <= REQ;
            end
          end
        end

        REQ: begin
          if (dreq_ready) begin
            dreq_valid <= 1'b0;
            if (req.we) begin
              rd_out    <= req.rd;
              op_out    <= req.op;
              wb_data   <= DATA_W'(dreq_addr);
              valid_out <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= WAIT_RSP;
            end
          end
        end

        WAIT_RSP: begin
          if (drsp_valid) begin
            rd_out    <= req.rd;
            op_out    <= req.op;
            wb_data   <= drsp_rdata;
            wb_en     <= (req.rd != 4'd0);
            valid_out <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU bypass, stalled load, store, illegal
// accesses, r0 writeback and asynchronous reset during an access.
module tb_mem_stage;
  import cpu_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rd_in, op_in;
  logic [31:0] alu_result_in, store_data_in;
  logic        mem_read_in, mem_write_in, valid_in;
  logic        ready_out, dreq_valid, dreq_ready, dreq_we;
  logic [31:0] dreq_addr, dreq_wdata;
  logic        drsp_valid;
  logic [31:0] drsp_rdata;
  logic [3:0]  rd_out, op_out;
  logic [31:0] wb_data;
  logic        wb_en, err_out, valid_out;

  int tests = 0;
  int fails = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .rd_in(rd_in), .op_in(op_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .valid_in(valid_in), .ready_out(ready_out),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
    .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata),
    .rd_out(rd_out), .op_out(op_out), .wb_data(wb_data), .wb_en(wb_en),
    .err_out(err_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rd, input logic [3:0] op, input logic [31:0] alu,
                       input logic [31:0] sdata, input logic rd_f, input logic wr_f);
    valid_in      = 1'b1;
    rd_in         = rd;
    op_in         = op;
    alu_result_in = alu;
    store_data_in = sdata;
    mem_read_in   = rd_f;
    mem_write_in  = wr_f;
  endtask

  task automatic idle_in();
    valid_in     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rd_in = '0; op_in = '0; alu_result_in = '0; store_data_in = '0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; valid_in = 1'b0;
    dreq_ready = 1'b0; drsp_valid = 1'b0; drsp_rdata = '0;
    #12;
    check("rst_dreq_valid", {31'd0, dreq_valid}, 32'd0);
    check("rst_valid_out",  {31'd0, valid_out}, 32'd0);
    check("rst_wb_data",    wb_data, 32'd0);
    check("rst_rd_out",     {28'd0, rd_out}, 32'd0);
    check("rst_dreq_addr",  dreq_addr, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_out", {31'd0, ready_out}, 32'd1);

    // ALU pass-through, back to back
    tick();
    drive(4'd5, OP_ADD, 32'h30, 32'h0, 1'b0, 1'b0);
    tick();
    check("alu1_valid", {31'd0, valid_out}, 32'd1);
    check("alu1_data",  wb_data, 32'h30);
    check("alu1_wb_en", {31'd0, wb_en}, 32'd1);
    check("alu1_rd",    {28'd0, rd_out}, 32'd5);
    drive(4'd6, OP_SUB, 32'h44, 32'h0, 1'b0, 1'b0);
    tick();
    check("alu2_valid", {31'd0, valid_out}, 32'd1);
    check("alu2_data",  wb_data, 32'h44);
    check("alu2_op",    {28'd0, op_out}, {28'd0, OP_SUB});
    drive(4'd0, OP_ADD, 32'h55, 32'h0, 1'b0, 1'b0);
    tick();
    check("alu3_valid", {31'd0, valid_out}, 32'd1);
    check("alu3_wb_en_r0", {31'd0, wb_en}, 32'd0);
    idle_in();
    tick();
    check("alu_idle_valid", {31'd0, valid_out}, 32'd0);
    check("alu_hold_data",  wb_data, 32'h55);

    // Load with two request stall cycles and a late response
    drive(4'd3, OP_LOAD, 32'h100, 32'h0, 1'b1, 1'b0);
    dreq_ready = 1'b0;
    tick();
    idle_in();
    check("ld_dreq_valid", {31'd0, dreq_valid}, 32'd1);
    check("ld_addr",       dreq_addr, 32'h100);
    check("ld_we",         {31'd0, dreq_we}, 32'd0);
    check("ld_ready_out",  {31'd0, ready_out}, 32'd0);
    tick();
    check("ld_stall_valid", {31'd0, dreq_valid}, 32'd1);
    check("ld_stall_addr",  dreq_addr, 32'h100);
    check("ld_stall_ready", {31'd0, ready_out}, 32'd0);
    dreq_ready = 1'b1;
    tick();
    dreq_ready = 1'b0;
    check("ld_req_drop",  {31'd0, dreq_valid}, 32'd0);
    check("ld_wait_ready", {31'd0, ready_out}, 32'd0);
    tick();
    tick();
    check("ld_wait2_ready", {31'd0, ready_out}, 32'd0);
    check("ld_wait2_valid", {31'd0, valid_out}, 32'd0);
    drsp_valid = 1'b1;
    drsp_rdata = 32'hDEAD_BEEF;
    tick();
    drsp_valid = 1'b0;
    check("ld_valid_out", {31'd0, valid_out}, 32'd1);
    check("ld_wb_data",   wb_data, 32'hDEAD_BEEF);
    check("ld_wb_en",     {31'd0, wb_en}, 32'd1);
    check("ld_rd_out",    {28'd0, rd_out}, 32'd3);
    check("ld_op_out",    {28'd0, op_out}, {28'd0, OP_LOAD});
    check("ld_ready_back", {31'd0, ready_out}, 32'd1);
    tick();
    check("ld_pulse", {31'd0, valid_out}, 32'd0);

    // Store accepted immediately
    drive(4'd0, OP_STORE, 32'h204, 32'h1234_5678, 1'b0, 1'b1);
    dreq_ready = 1'b1;
    tick();
    idle_in();
    check("st_dreq_valid", {31'd0, dreq_valid}, 32'd1);
    check("st_we",         {31'd0, dreq_we}, 32'd1);
    check("st_wdata",      dreq_wdata, 32'h1234_5678);
    check("st_addr",       dreq_addr, 32'h204);
    check("st_early_valid", {31'd0, valid_out}, 32'd0);
    tick();
    dreq_ready = 1'b0;
    check("st_valid_out", {31'd0, valid_out}, 32'd1);
    check("st_wb_en",     {31'd0, wb_en}, 32'd0);
    check("st_wb_data",   wb_data, 32'h204);
    check("st_err",       {31'd0, err_out}, 32'd0);
    check("st_req_drop",  {31'd0, dreq_valid}, 32'd0);

    // Misaligned load, then both flags set
    drive(4'd7, OP_LOAD, 32'h102, 32'h0, 1'b1, 1'b0);
    tick();
    check("mis_dreq_valid", {31'd0, dreq_valid}, 32'd0);
    check("mis_valid_out",  {31'd0, valid_out}, 32'd1);
    check("mis_err",        {31'd0, err_out}, 32'd1);
    check("mis_wb_en",      {31'd0, wb_en}, 32'd0);
    check("mis_wb_data",    wb_data, 32'h102);
    drive(4'd7, OP_LOAD, 32'h200, 32'h0, 1'b1, 1'b1);
    tick();
    idle_in();
    check("both_dreq_valid", {31'd0, dreq_valid}, 32'd0);
    check("both_err",        {31'd0, err_out}, 32'd1);
    check("both_ready",      {31'd0, ready_out}, 32'd1);
    tick();
    check("err_clear", {31'd0, err_out}, 32'd0);
    check("err_dreq_idle", {31'd0, dreq_valid}, 32'd0);

    // Load to r0 completes without a register write
    drive(4'd0, OP_LOAD, 32'h300, 32'h0, 1'b1, 1'b0);
    dreq_ready = 1'b1;
    tick();
    idle_in();
    tick();
    dreq_ready = 1'b0;
    drsp_valid = 1'b1;
    drsp_rdata = 32'h0000_CAFE;
    tick();
    drsp_valid = 1'b0;
    check("r0_valid_out", {31'd0, valid_out}, 32'd1);
    check("r0_wb_en",     {31'd0, wb_en}, 32'd0);
    check("r0_wb_data",   wb_data, 32'h0000_CAFE);

    // Asynchronous reset while waiting for a load response
    drive(4'd9, OP_LOAD, 32'h40, 32'h0, 1'b1, 1'b0);
    dreq_ready = 1'b1;
    tick();
    idle_in();
    tick();
    dreq_ready = 1'b0;
    check("wr_waiting", {31'd0, ready_out}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("wr_rst_wb_data", wb_data, 32'd0);
    check("wr_rst_valid",   {31'd0, valid_out}, 32'd0);
    check("wr_rst_dreq",    {31'd0, dreq_valid}, 32'd0);

    // Asynchronous reset while a request is pending
    tick();
    rst_n = 1'b1;
    drive(4'd2, OP_LOAD, 32'h80, 32'h0, 1'b1, 1'b0);
    tick();
    idle_in();
    check("rq_dreq_valid", {31'd0, dreq_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rq_rst_dreq", {31'd0, dreq_valid}, 32'd0);
    check("rq_rst_addr", dreq_addr, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rq_ready_after", {31'd0, ready_out}, 32'd1);
    drsp_valid = 1'b1;
    drsp_rdata = 32'h1111_2222;
    tick();
    drsp_valid = 1'b0;
    check("stray_valid", {31'd0, valid_out}, 32'd0);
    check("stray_wb_data", wb_data, 32'd0);
    check("stray_ready", {31'd0, ready_out}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
